// File: rtl/banked_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// banked_sram_ctrl_if
//   Request/response bundle between a load/store requester and the banked
//   SRAM controller.
//
//   master : requester side (drives mem_en and req_*, observes the rest)
//   slave  : controller side
//
//   mem_en     global enable, gates request acceptance
//   req_valid  request present
//   req_ready  controller can accept this cycle
//   req_we     1 = write, 0 = read
//   req_addr   {bank select, word index}
//   req_wdata  write data
//   rsp_valid  one-cycle read-data strobe
//   rsp_data   read data, holds between responses
//   rsp_bank   bank that produced rsp_data
//   init_done  clear sweep finished
// ---------------------------------------------------------------------------
interface banked_sram_ctrl_if #(
    parameter int DATA_W    = 8,
    parameter int BANK_AW   = 10,
    parameter int NUM_BANKS = 2
);
    localparam int BANK_SW = $clog2(NUM_BANKS);
    localparam int ADDR_W  = BANK_AW + BANK_SW;

    logic              mem_en;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [BANK_SW-1:0] rsp_bank;
    logic              init_done;

    modport master (
        output mem_en, req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_bank, init_done
    );

    modport slave (
        input  mem_en, req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_bank, init_done
    );
endinterface

// File: rtl/banked_sram_ctrl.sv
// ---------------------------------------------------------------------------
// banked_sram_ctrl
//   Synchronous multi-bank word memory behind a valid/ready request port.
//   After reset every word of every bank is cleared by a sweep that writes
//   one index per cycle in all banks in parallel; requests are accepted only
//   once the sweep has finished. Reads return one cycle after acceptance on a
//   registered response port; writes have no response.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    banked_sram_ctrl_if.slave (request, response and status signals)
// ---------------------------------------------------------------------------
module banked_sram_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BANK_AW   = 10,
    parameter int NUM_BANKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    banked_sram_ctrl_if.slave     bus
);
    localparam int BANK_SW = $clog2(NUM_BANKS);
    localparam int ADDR_W  = BANK_AW + BANK_SW;
    localparam int DEPTH   = 1 << BANK_AW;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t             state;
    logic [BANK_AW-1:0] cnt;

    logic [DATA_W-1:0]  mem [NUM_BANKS][DEPTH];

    logic [BANK_SW-1:0] sel;
    logic [BANK_AW-1:0] idx;
    logic               accept;
    logic               wr_accept;
    logic               rd_accept;

    // Bank select is the top of the address; word index is the bottom.
    assign sel = bus.req_addr[ADDR_W-1 -: BANK_SW];
    assign idx = bus.req_addr[BANK_AW-1:0];

    // The only combinational output: readiness depends on state and mem_en,
    // never on the request itself, so no req_* -> req_ready loop exists.
    assign bus.req_ready = (state == ST_READY) && bus.mem_en;

    assign accept    = bus.req_valid && bus.req_ready;
    assign wr_accept = accept &&  bus.req_we;
    assign rd_accept = accept && !bus.req_we;

    // NOTE: the storage array has no reset branch; an asynchronous reset on
    // a RAM array cannot map onto SRAM macros. Contents are cleared instead
    // by the INIT sweep, which is the only state the block can be in while
    // (and after) reset is asserted.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state == ST_INIT) begin
                mem[b][cnt] <= '0;
            end else if (wr_accept && (sel == BANK_SW'(b))) begin
                mem[b][idx] <= bus.req_wdata;
            end
        end
    end

    // Control FSM with registered status and response outputs.
    // NOTE: every assignment here is non-blocking so that all registers see
    // the pre-edge values of state, cnt and the memory; a blocking write would
    // let later statements observe the updated value within the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            cnt           <= '0;
            bus.init_done <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_bank  <= '0;
        end else begin
            // One-cycle strobe; data and bank hold until the next read.
            bus.rsp_valid <= rd_accept;
            if (rd_accept) begin
                bus.rsp_data <= mem[sel][idx];
                bus.rsp_bank <= sel;
            end

            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {BANK_AW{1'b1}}) begin
                        state         <= ST_READY;
                        bus.init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_banked_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_banked_sram_ctrl
//   Self-checking bench for banked_sram_ctrl with default parameters
//   (8-bit words, 2 banks of 1024). The reference model is a flat array of
//   2048 words indexed by the full address; bank number is simply the top
//   address bit. Inputs change on the falling edge, outputs are compared
//   on the falling edge (or 1 ns after an event for asynchronous checks).
// ---------------------------------------------------------------------------
module tb_banked_sram_ctrl;
    localparam int DATA_W    = 8;
    localparam int BANK_AW   = 10;
    localparam int NUM_BANKS = 2;
    localparam int ADDR_W    = 11;
    localparam int WORDS     = 2048;
    localparam int SWEEP     = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    banked_sram_ctrl_if #(
        .DATA_W   (DATA_W),
        .BANK_AW  (BANK_AW),
        .NUM_BANKS(NUM_BANKS)
    ) bus ();

    banked_sram_ctrl #(
        .DATA_W   (DATA_W),
        .BANK_AW  (BANK_AW),
        .NUM_BANKS(NUM_BANKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [WORDS];
    bit                model_ready;
    bit                exp_valid;
    logic [DATA_W-1:0] last_data;
    logic              last_bank;

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        model_ready = 1'b0;
        exp_valid   = 1'b0;
        last_data   = '0;
        last_bank   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // One bus cycle, entered and left on a falling edge. Drives the request,
    // checks req_ready, lets the model decide acceptance from its own view
    // of readiness, then checks the response registered at the edge.
    task automatic step(input bit en, input bit v, input bit we,
                        input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input string tag);
        bit accept;
        bus.mem_en    = en;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        #1;
        checks++;
        if (bus.req_ready !== (model_ready && en)) begin
            errors++;
            $display("FAIL %s req_ready: got %0b expected %0b", tag, bus.req_ready, model_ready && en);
        end
        @(posedge clk);
        accept    = v && en && model_ready;
        exp_valid = accept && !we;
        if (accept && we) ref_mem[addr] = wd;
        if (exp_valid) begin
            last_data = ref_mem[addr];
            last_bank = addr[ADDR_W-1];
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s rsp_valid: got %0b expected %0b", tag, bus.rsp_valid, exp_valid);
        end
        checks++;
        if (bus.rsp_data !== last_data || bus.rsp_bank !== last_bank) begin
            errors++;
            $display("FAIL %s rsp_data/bank: got %02h/%0d expected %02h/%0d", tag,
                     bus.rsp_data, bus.rsp_bank, last_data, last_bank);
        end
    endtask

    // Release reset on a falling edge and count rising edges to init_done.
    task automatic release_and_sweep(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * SWEEP; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.init_done === 1'b1) break;
        end
        checks++;
        if (bus.init_done !== 1'b1 || n != SWEEP) begin
            errors++;
            $display("FAIL %s sweep: init_done=%0b after %0d edges, expected 1 after %0d", tag, bus.init_done, n, SWEEP);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready after sweep: got %0b expected 1", tag, bus.req_ready);
        end
        model_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.init_done !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_data !== '0 || bus.rsp_bank !== '0) begin
            errors++;
            $display("FAIL %s reset values: init_done=%0b req_ready=%0b rsp_valid=%0b rsp_data=%02h rsp_bank=%0d expected all 0",
                     tag, bus.init_done, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_bank);
        end
    endtask

    task automatic test_reset();
        model_reset();
        idle_inputs();
        bus.mem_en = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        release_and_sweep("reset");
        step(1, 1, 0, 11'd1,    8'h00, "reset_rd1");
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00 || bus.rsp_bank !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd1 cleared: got v=%0b %02h bank %0d expected v=1 00 bank 0", bus.rsp_valid, bus.rsp_data, bus.rsp_bank);
        end
        step(1, 1, 0, 11'd1025, 8'h00, "reset_rd1025");
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00 || bus.rsp_bank !== 1'b1) begin
            errors++;
            $display("FAIL reset_rd1025 cleared: got v=%0b %02h bank %0d expected v=1 00 bank 1", bus.rsp_valid, bus.rsp_data, bus.rsp_bank);
        end
        step(1, 0, 0, 11'd0, 8'h00, "reset_idle");
    endtask

    task automatic test_bank_isolation();
        step(1, 1, 1, 11'd1,    8'hA5, "iso_wr1");
        step(1, 1, 1, 11'd1025, 8'h5A, "iso_wr1025");
        step(1, 1, 0, 11'd1,    8'h00, "iso_rd1");
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hA5 || bus.rsp_bank !== 1'b0) begin
            errors++;
            $display("FAIL iso_rd1: got v=%0b %02h bank %0d expected v=1 a5 bank 0", bus.rsp_valid, bus.rsp_data, bus.rsp_bank);
        end
        step(1, 1, 0, 11'd1025, 8'h00, "iso_rd1025");
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A || bus.rsp_bank !== 1'b1) begin
            errors++;
            $display("FAIL iso_rd1025: got v=%0b %02h bank %0d expected v=1 5a bank 1", bus.rsp_valid, bus.rsp_data, bus.rsp_bank);
        end
        step(1, 0, 0, 11'd0, 8'h00, "iso_idle");
    endtask

    task automatic test_boundaries();
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W-1:0] vals  [4];
        addrs = '{11'd0, 11'd1023, 11'd1024, 11'd2047};
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1, 1, 1, addrs[i], vals[i], "bnd_wr");
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, addrs[i], 8'h00, "bnd_rd");
            checks++;
            if (bus.rsp_data !== vals[i] || bus.rsp_bank !== addrs[i][ADDR_W-1]) begin
                errors++;
                $display("FAIL bnd_rd addr %0d: got %02h bank %0d expected %02h bank %0d",
                         addrs[i], bus.rsp_data, bus.rsp_bank, vals[i], addrs[i][ADDR_W-1]);
            end
        end
        step(1, 0, 0, 11'd0, 8'h00, "bnd_idle");
    endtask

    task automatic test_write_then_read();
        step(1, 1, 1, 11'd54, 8'h3C, "wtr_wr");
        step(1, 1, 0, 11'd54, 8'h00, "wtr_rd");
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h3C) begin
            errors++;
            $display("FAIL wtr_rd: got v=%0b %02h expected v=1 3c", bus.rsp_valid, bus.rsp_data);
        end
        step(1, 0, 0, 11'd0, 8'h00, "wtr_idle");
    endtask

    task automatic test_mem_en_gating();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 11'd25, 8'hFF, "gate_blocked_wr");
        step(1, 1, 0, 11'd25, 8'h00, "gate_rd25");
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL gate_rd25: got v=%0b %02h expected v=1 00", bus.rsp_valid, bus.rsp_data);
        end
        // Read accepted, then mem_en drops before the response is observed.
        bus.mem_en    = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 11'd1025;
        @(posedge clk);
        #1;
        bus.mem_en    = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL gate_drop req_ready: got %0b expected 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A || bus.rsp_bank !== 1'b1) begin
            errors++;
            $display("FAIL gate_drop response: got v=%0b %02h bank %0d expected v=1 5a bank 1", bus.rsp_valid, bus.rsp_data, bus.rsp_bank);
        end
        last_data = 8'h5A;
        last_bank = 1'b1;
        @(negedge clk);
        step(0, 1, 0, 11'd1025, 8'h00, "gate_held_rd");
        step(1, 0, 0, 11'd0, 8'h00, "gate_idle");
    endtask

    task automatic test_random(input int n, input string tag);
        logic [ADDR_W-1:0] corner [6];
        logic [ADDR_W-1:0] a;
        corner = '{11'd0, 11'd1, 11'd1023, 11'd1024, 11'd1025, 11'd2047};
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 5)];
            else                           a = ADDR_W'($urandom_range(0, WORDS - 1));
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 a, DATA_W'($urandom), tag);
        end
        step(1, 0, 0, 11'd0, 8'h00, "rand_idle");
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        bus.mem_en = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        checks++;
        if (bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_init init_done: got %0b expected 0", bus.init_done);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_init");
        release_and_sweep("mid_init");
    endtask

    task automatic test_reset_ready();
        step(1, 1, 1, 11'd77, 8'hC3, "rr_wr");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 11'd77;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_reset_values("rr_async");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin
                errors++;
                $display("FAIL rr_dropped cycle %0d: got v=%0b %02h expected v=0 00", i, bus.rsp_valid, bus.rsp_data);
            end
        end
    endtask

    initial begin
        bus.mem_en = 1'b0;
        idle_inputs();
        test_reset();
        test_bank_isolation();
        test_boundaries();
        test_write_then_read();
        test_mem_en_gating();
        test_random(300, "rand_a");
        test_reset_mid_init();
        test_random(300, "rand_b");
        test_reset_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
